// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the HI/LO datapath (multiply and divide units).
//   state_t   : sequencer states of the iterative units (IDLE/CALC/DONE)
//   WIDTH     : operand width
//   ITER      : Booth steps per multiply
//   HI_*/LO_* : bit positions of the HI and LO words inside the packed Z result
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    // Packed {HI, LO} layout of the 2*WIDTH-bit result, common to mul and div.
    localparam int HI_MSB = 2*WIDTH - 1;
    localparam int HI_LSB = WIDTH;
    localparam int LO_MSB = WIDTH - 1;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_multiplier_if.sv
// -----------------------------------------------------------------------------
// booth_multiplier_if
// Request/result bundle of the Booth multiplier.
//   start        : request pulse (master -> slave)
//   Multiplicand : signed operand M (master -> slave)
//   Multiplier   : signed operand Q (master -> slave)
//   busy         : high while iterating (slave -> master)
//   done         : one-cycle strobe when Z is updated (slave -> master)
//   Z            : packed {HI, LO} product (slave -> master)
// -----------------------------------------------------------------------------
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     Multiplicand;
    logic [WIDTH-1:0]     Multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Z;

    modport master (
        output start, Multiplicand, Multiplier,
        input  busy, done, Z
    );

    modport slave (
        input  start, Multiplicand, Multiplier,
        output busy, done, Z
    );
endinterface

// File: rtl/booth_multiplier_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: add/subtract/keep the multiplicand
// according to {q[0], q_m1}, then arithmetic right shift of {A, Q, q-1} by one.
//   a, q, q_m1      : current accumulator, multiplier register, guard bit
//   m               : sign-extended multiplicand (WIDTH+1 bits)
//   a_next, q_next,
//   q_m1_next       : state after this step
// -----------------------------------------------------------------------------
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        // NOTE: default assignment first so no path leaves sum unassigned
        // (which would infer a latch).
        sum = a;
        unique case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic shift: replicate the accumulator MSB; the old q-1 falls off.
    assign {a_next, q_next, q_m1_next} = {sum[WIDTH], sum, q};

endmodule

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
// Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one step per clock.
// An accepted start loads the operands; 32 edges later Z holds the product and
// done pulses for one cycle. Z keeps its value until the next completion.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : booth_multiplier_if.slave (start, operands, busy, done, Z)
// -----------------------------------------------------------------------------
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    booth_multiplier_if.slave bus
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    state_t             state;
    logic [WIDTH:0]     a_reg;      // one guard bit so A - M cannot overflow for -2^(W-1)
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_m1;
    logic [CNT_W-1:0]   count;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] z_r;

    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_m1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1),
        .m         (m_reg),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // NOTE: every register here, datapath included, is cleared by reset so an
    // aborted operation leaves no stale operand or partial product behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_reg  <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            z_r    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout: every right-hand side
            // sees the pre-edge value, so the statement order does not matter.
            unique case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= CALC;
                        busy_r <= 1'b1;
                        a_reg  <= '0;
                        m_reg  <= {bus.Multiplicand[WIDTH-1], bus.Multiplicand};
                        q_reg  <= bus.Multiplier;
                        q_m1   <= 1'b0;
                        count  <= '0;
                    end else begin
                        state  <= IDLE;
                    end
                end

                CALC: begin
                    // start is deliberately not looked at here: no restart, no queue.
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        // Product is taken from the post-shift values of this step.
                        z_r[HI_MSB:HI_LSB] <= a_next[WIDTH-1:0];
                        z_r[LO_MSB:LO_LSB] <= q_next;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Z    = z_r;

endmodule
